// File: rtl/pmod_cls_spi_responder.sv
// pmod_cls_spi_responder
// SPI mode-0 responder that models the PMOD CLS display module. SCK/CSN/COPI are
// oversampled on the system clock, whole bytes are assembled MSB first, and the CLS
// byte stream (printable text, ESC[j, ESC[r;cH) is decoded into display strobes.
// Ports:
//   i_clk_20mhz, i_rst_20mhz      system clock, asynchronous active-high reset
//   ei_sck, ei_csn, ei_copi       SPI pins from the controller (mode 0)
//   eo_cipo_o, eo_cipo_t          CIPO data and tristate enable (1 = high-Z)
//   i_tx_byte                     byte returned on CIPO
//   o_rx_byte, o_rx_valid         last received byte and its 1-clk strobe
//   o_clear_display               1-clk strobe on ESC[j
//   o_char_wr/row/col/data        character write strobe, position and code
//   o_cmd_err, o_frame_err        malformed command / truncated byte strobes
module pmod_cls_spi_responder #(
    parameter int unsigned parm_cols        = 16,
    parameter int unsigned parm_rows        = 2,
    parameter int unsigned parm_sync_stages = 2,
    localparam int unsigned col_w = ($clog2(parm_cols) > 0) ? $clog2(parm_cols) : 1,
    localparam int unsigned row_w = ($clog2(parm_rows) > 0) ? $clog2(parm_rows) : 1
) (
    input  logic             i_clk_20mhz,
    input  logic             i_rst_20mhz,
    input  logic             ei_sck,
    input  logic             ei_csn,
    input  logic             ei_copi,
    output logic             eo_cipo_o,
    output logic             eo_cipo_t,
    input  logic [7:0]       i_tx_byte,
    output logic [7:0]       o_rx_byte,
    output logic             o_rx_valid,
    output logic             o_clear_display,
    output logic             o_char_wr,
    output logic [row_w-1:0] o_char_row,
    output logic [col_w-1:0] o_char_col,
    output logic [7:0]       o_char_data,
    output logic             o_cmd_err,
    output logic             o_frame_err
);

    typedef enum logic [1:0] {ST_TEXT, ST_ESC, ST_CSI} state_t;

    // Input synchronisers; CSN resets to its idle (deasserted) level.
    logic [parm_sync_stages-1:0] sck_sync, csn_sync, copi_sync;
    logic sck_d, csn_d;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            copi_sync <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[parm_sync_stages-2:0], ei_sck};
            csn_sync  <= {csn_sync[parm_sync_stages-2:0], ei_csn};
            copi_sync <= {copi_sync[parm_sync_stages-2:0], ei_copi};
            sck_d     <= sck_sync[parm_sync_stages-1];
            csn_d     <= csn_sync[parm_sync_stages-1];
        end
    end

    logic sck_s, csn_s, copi_s;
    assign sck_s  = sck_sync[parm_sync_stages-1];
    assign csn_s  = csn_sync[parm_sync_stages-1];
    assign copi_s = copi_sync[parm_sync_stages-1];

    // Byte engine. TX register is held unshifted; the bit driven after k rises is tx_sr[7-k].
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            eo_cipo_o   <= 1'b0;
            eo_cipo_t   <= 1'b1;
            o_rx_byte   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            if (csn_s) begin
                bit_cnt   <= '0;
                eo_cipo_t <= 1'b1;
                if (!csn_d && bit_cnt != 3'd0) o_frame_err <= 1'b1;
            end else if (csn_d) begin
                eo_cipo_t <= 1'b0;
                tx_sr     <= i_tx_byte;
                eo_cipo_o <= i_tx_byte[7];
            end else if (sck_s && !sck_d) begin
                rx_sr   <= {rx_sr[5:0], copi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_rx_byte  <= {rx_sr, copi_s};
                    o_rx_valid <= 1'b1;
                    tx_sr      <= i_tx_byte;
                end
            end else if (!sck_s && sck_d) begin
                eo_cipo_o <= tx_sr[~bit_cnt];
            end
        end
    end

    // CLS command parser, advancing once per received byte.
    state_t           state, state_nx;
    logic [row_w-1:0] row, row_nx, char_row_nx;
    logic [col_w-1:0] col, col_nx, char_col_nx;
    logic [7:0]       p0, p0_nx, p1, p1_nx, char_data_nx, digit_val;
    logic             psel, psel_nx, char_wr_nx, clear_nx, err_nx;
    logic [11:0]      digit_acc;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state           <= ST_TEXT;
            row             <= '0;
            col             <= '0;
            p0              <= '0;
            p1              <= '0;
            psel            <= 1'b0;
            o_char_wr       <= 1'b0;
            o_char_row      <= '0;
            o_char_col      <= '0;
            o_char_data     <= '0;
            o_clear_display <= 1'b0;
            o_cmd_err       <= 1'b0;
        end else begin
            state           <= state_nx;
            row             <= row_nx;
            col             <= col_nx;
            p0              <= p0_nx;
            p1              <= p1_nx;
            psel            <= psel_nx;
            o_char_wr       <= char_wr_nx;
            o_char_row      <= char_row_nx;
            o_char_col      <= char_col_nx;
            o_char_data     <= char_data_nx;
            o_clear_display <= clear_nx;
            o_cmd_err       <= err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        row_nx       = row;
        col_nx       = col;
        p0_nx        = p0;
        p1_nx        = p1;
        psel_nx      = psel;
        char_wr_nx   = 1'b0;
        char_row_nx  = o_char_row;
        char_col_nx  = o_char_col;
        char_data_nx = o_char_data;
        clear_nx     = 1'b0;
        err_nx       = 1'b0;
        // Decimal accumulate into the selected parameter, saturating at 255.
        digit_acc    = 12'(psel ? p1 : p0) * 12'd10 + 12'(o_rx_byte[3:0]);
        digit_val    = (digit_acc > 12'd255) ? 8'd255 : digit_acc[7:0];

        if (o_rx_valid) begin
            case (state)
                ST_TEXT: begin
                    if (o_rx_byte == 8'h1B) begin
                        state_nx = ST_ESC;
                    end else if (o_rx_byte >= 8'h20 && o_rx_byte <= 8'h7E) begin
                        char_wr_nx   = 1'b1;
                        char_row_nx  = row;
                        char_col_nx  = col;
                        char_data_nx = o_rx_byte;
                        col_nx       = (32'(col) == parm_cols - 1) ? '0 : col + col_w'(1);
                    end
                end
                ST_ESC: begin
                    if (o_rx_byte == 8'h5B) begin
                        state_nx = ST_CSI;
                        p0_nx    = '0;
                        p1_nx    = '0;
                        psel_nx  = 1'b0;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ST_TEXT;
                    end
                end
                ST_CSI: begin
                    if (o_rx_byte >= 8'h30 && o_rx_byte <= 8'h39) begin
                        if (psel) p1_nx = digit_val;
                        else      p0_nx = digit_val;
                    end else if (o_rx_byte == 8'h3B) begin
                        if (psel) begin
                            err_nx   = 1'b1;
                            state_nx = ST_TEXT;
                        end else begin
                            psel_nx = 1'b1;
                        end
                    end else if (o_rx_byte == 8'h6A) begin
                        clear_nx = 1'b1;
                        row_nx   = '0;
                        col_nx   = '0;
                        state_nx = ST_TEXT;
                    end else if (o_rx_byte == 8'h48) begin
                        if (32'(p0) < parm_rows && 32'(p1) < parm_cols) begin
                            row_nx = row_w'(p0);
                            col_nx = col_w'(p1);
                        end else begin
                            err_nx = 1'b1;
                        end
                        state_nx = ST_TEXT;
                    end else if (o_rx_byte == 8'h1B) begin
                        err_nx   = 1'b1;
                        state_nx = ST_ESC;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ST_TEXT;
                    end
                end
                default: state_nx = ST_TEXT;
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Bench for pmod_cls_spi_responder: bit-bangs SPI mode 0 at 2.5 MHz, records every
// strobe the DUT emits and compares it with a byte-stream model of the CLS protocol.
module tb_pmod_cls_spi_responder;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0, csn = 1'b1, copi = 1'b0;
    logic       cipo_o, cipo_t;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_byte;
    logic       rx_valid, clear_display, char_wr, cmd_err, frame_err;
    logic [0:0] char_row;
    logic [3:0] char_col;
    logic [7:0] char_data;

    pmod_cls_spi_responder dut (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst),
        .ei_sck(sck), .ei_csn(csn), .ei_copi(copi),
        .eo_cipo_o(cipo_o), .eo_cipo_t(cipo_t),
        .i_tx_byte(tx_byte), .o_rx_byte(rx_byte), .o_rx_valid(rx_valid),
        .o_clear_display(clear_display), .o_char_wr(char_wr),
        .o_char_row(char_row), .o_char_col(char_col), .o_char_data(char_data),
        .o_cmd_err(cmd_err), .o_frame_err(frame_err)
    );

    always #25 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Event word: {kind, row, col, data}; kind 1 = char write, 2 = clear, 3 = command error.
    logic [31:0] got_q[$], exp_q[$];
    logic [7:0]  rx_q[$], sent_q[$], stim_q[$];
    int          n_ferr = 0, exp_ferr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (char_wr)       got_q.push_back({8'd1, 8'(char_row), 8'(char_col), char_data});
            if (clear_display) got_q.push_back({8'd2, 24'd0});
            if (cmd_err)       got_q.push_back({8'd3, 24'd0});
            if (rx_valid)      rx_q.push_back(rx_byte);
            if (frame_err)     n_ferr++;
        end
    end

    // Reference model of the CLS byte stream.
    int m_state = 0, m_row = 0, m_col = 0, m_p0 = 0, m_p1 = 0, m_psel = 0;

    task automatic model_reset();
        m_state = 0; m_row = 0; m_col = 0; m_p0 = 0; m_p1 = 0; m_psel = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v;
        case (m_state)
            0: begin
                if (b == 8'h1B) m_state = 1;
                else if (b >= 8'h20 && b <= 8'h7E) begin
                    exp_q.push_back({8'd1, 8'(m_row), 8'(m_col), b});
                    m_col = (m_col + 1) % COLS;
                end
            end
            1: begin
                if (b == 8'h5B) begin m_state = 2; m_p0 = 0; m_p1 = 0; m_psel = 0; end
                else begin exp_q.push_back({8'd3, 24'd0}); m_state = 0; end
            end
            default: begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    v = (m_psel != 0 ? m_p1 : m_p0) * 10 + int'(b) - 48;
                    if (v > 255) v = 255;
                    if (m_psel != 0) m_p1 = v; else m_p0 = v;
                end else if (b == 8'h3B) begin
                    if (m_psel != 0) begin exp_q.push_back({8'd3, 24'd0}); m_state = 0; end
                    else m_psel = 1;
                end else if (b == 8'h6A) begin
                    exp_q.push_back({8'd2, 24'd0}); m_row = 0; m_col = 0; m_state = 0;
                end else if (b == 8'h48) begin
                    if (m_p0 < ROWS && m_p1 < COLS) begin m_row = m_p0; m_col = m_p1; end
                    else exp_q.push_back({8'd3, 24'd0});
                    m_state = 0;
                end else if (b == 8'h1B) begin
                    exp_q.push_back({8'd3, 24'd0}); m_state = 1;
                end else begin
                    exp_q.push_back({8'd3, 24'd0}); m_state = 0;
                end
            end
        endcase
    endtask

    task automatic frame_begin(input logic [7:0] tx);
        tx_byte = tx;
        csn = 1'b0;
        #(2 * HALF);
    endtask

    task automatic frame_end();
        #HALF;
        csn = 1'b1;
        #(2 * HALF);
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        #HALF;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
    endtask

    // Sends one byte, checks the CIPO bits seen just before each rising edge.
    task automatic send_byte(input logic [7:0] b);
        logic [7:0] seen;
        for (int i = 7; i >= 0; i--) begin
            copi = b[i];
            #HALF;
            seen[i] = cipo_o;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        check("cipo_bits", 32'(seen), 32'(tx_byte));
        sent_q.push_back(b);
        model_byte(b);
    endtask

    task automatic send_frame(input logic [7:0] tx);
        frame_begin(tx);
        while (stim_q.size() > 0) send_byte(stim_q.pop_front());
        frame_end();
    endtask

    task automatic compare_all(input string tag);
        int n;
        repeat (10) @(negedge clk);
        check({tag, "_evt_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_evt"}, got_q[i], exp_q[i]);
        check({tag, "_rx_cnt"}, 32'(rx_q.size()), 32'(sent_q.size()));
        n = (rx_q.size() < sent_q.size()) ? rx_q.size() : sent_q.size();
        for (int i = 0; i < n; i++) check({tag, "_rx"}, 32'(rx_q[i]), 32'(sent_q[i]));
        check({tag, "_frame_err"}, 32'(n_ferr), 32'(exp_ferr));
        got_q.delete(); exp_q.delete(); rx_q.delete(); sent_q.delete();
    endtask

    function automatic logic [31:0] last_got();
        return (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hFFFF_FFFF;
    endfunction

    task automatic push_num(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(8'(s[i]));
    endtask

    task automatic gen_stream(input int n);
        int r;
        repeat (n) begin
            r = $urandom_range(0, 99);
            if (r < 50) stim_q.push_back(8'($urandom_range(32, 126)));
            else if (r < 62) begin
                stim_q.push_back(8'h1B); stim_q.push_back(8'h5B);
                if ($urandom_range(0, 3) != 0) push_num($urandom_range(0, 3));
                stim_q.push_back(8'h3B);
                if ($urandom_range(0, 3) != 0) push_num($urandom_range(0, 20));
                stim_q.push_back(8'h48);
            end else if (r < 68) begin
                stim_q.push_back(8'h1B); stim_q.push_back(8'h5B); stim_q.push_back(8'h6A);
            end else if (r < 76) stim_q.push_back(8'($urandom_range(0, 255)));
            else if (r < 82) begin
                stim_q.push_back(8'h1B); stim_q.push_back(8'($urandom_range(0, 255)));
            end else if (r < 88) begin
                stim_q.push_back(8'h1B); stim_q.push_back(8'h5B);
                push_num(999); stim_q.push_back(8'h48);
            end else begin
                stim_q.push_back(8'h1B); stim_q.push_back(8'h5B);
                stim_q.push_back(8'h3B); stim_q.push_back(8'h3B);
            end
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #10 rst = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_cipo_t", 32'(cipo_t), 32'd1);
        check("rst_cipo_o", 32'(cipo_o), 32'd0);
        check("rst_strobes", {27'd0, rx_valid, clear_display, char_wr, cmd_err, frame_err}, 32'd0);
        check("rst_char", {8'd0, 8'(char_row), 8'(char_col), char_data}, 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);

        // Plain text from home.
        stim_q = '{8'h41, 8'h42};
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("ab_last", last_got(), {8'd1, 8'd0, 8'd1, 8'h42});
        compare_all("ab");

        // Cursor positioning then write.
        stim_q = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h35, 8'h48, 8'h5A};
        send_frame(8'h11);
        repeat (10) @(negedge clk);
        check("pos_last", last_got(), {8'd1, 8'd1, 8'd5, 8'h5A});
        compare_all("pos");

        // Clear display, then write at home.
        stim_q = '{8'h1B, 8'h5B, 8'h6A, 8'h78};
        send_frame(8'h5A);
        repeat (10) @(negedge clk);
        check("clr_last", last_got(), {8'd1, 8'd0, 8'd0, 8'h78});
        compare_all("clr");

        // Out-of-range cursor, unsupported escape, home, then 17 characters to wrap.
        stim_q = '{8'h1B, 8'h5B, 8'h32, 8'h3B, 8'h30, 8'h48, 8'h1B, 8'h5B, 8'h71,
                   8'h1B, 8'h5B, 8'h48};
        for (int i = 0; i < 17; i++) stim_q.push_back(8'(8'h61 + i));
        send_frame(8'hC3);
        repeat (10) @(negedge clk);
        check("wrap_last", last_got(), {8'd1, 8'd0, 8'd0, 8'h71});
        compare_all("err_wrap");

        // CIPO pattern and tristate release.
        stim_q = '{8'h3C};
        frame_begin(8'hA5);
        check("cipo_t_active", 32'(cipo_t), 32'd0);
        check("cipo_first", 32'(cipo_o), 32'd1);
        send_byte(stim_q.pop_front());
        frame_end();
        check("cipo_t_idle", 32'(cipo_t), 32'd1);
        check("rx_byte_3c", 32'(rx_byte), 32'h3C);
        compare_all("cipo");

        // Truncated byte, then a full byte still decodes.
        frame_begin(8'h00);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        frame_end();
        exp_ferr++;
        stim_q = '{8'h51};
        send_frame(8'h00);
        compare_all("frame");

        // Reset mid-escape and mid-byte: back to text mode at home with no strobes.
        stim_q = '{8'h1B, 8'h5B};
        frame_begin(8'h00);
        while (stim_q.size() > 0) send_byte(stim_q.pop_front());
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        compare_all("pre_rst");
        rst = 1'b1;
        #1;
        check("rst_async", {27'd0, rx_valid, clear_display, char_wr, cmd_err, frame_err}, 32'd0);
        check("rst_async_t", 32'(cipo_t), 32'd1);
        #300 rst = 1'b0;
        model_reset();
        frame_end();
        stim_q = '{8'h5A};
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("rst_last", last_got(), {8'd1, 8'd0, 8'd0, 8'h5A});
        compare_all("rst_mid");

        // Randomized streams over several frames.
        for (int f = 0; f < 10; f++) begin
            int k;
            gen_stream(6);
            frame_begin(8'($urandom_range(0, 255)));
            k = 0;
            while (stim_q.size() > 0) begin
                send_byte(stim_q.pop_front());
                k++;
                if (k % 7 == 0 && stim_q.size() > 0) begin
                    frame_end();
                    frame_begin(8'($urandom_range(0, 255)));
                end
            end
            frame_end();
            compare_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
